// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display scanner: segment patterns and index sizing.
package bcd_disp_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Active-low {g,f,e,d,c,b,a} patterns for codes 0..9
   localparam logic [6:0] SEG_PAT [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   function automatic int unsigned idx_width(input int unsigned digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Counter-side inputs and display-side outputs of the BCD display scanner.
interface bcd_display_scanner_if #(
   parameter int unsigned DIGITS = 4
) ();

   logic [4*DIGITS-1:0] bcd_in;
   logic                freeze;
   logic                lzb;
   logic                err_clr;
   logic [4*DIGITS-1:0] digit_q;
   logic                upd;
   logic                err;
   logic [6:0]          seg;
   logic [DIGITS-1:0]   an;

   modport master (
      output bcd_in, freeze, lzb, err_clr,
      input  digit_q, upd, err, seg, an
   );

   modport slave (
      input  bcd_in, freeze, lzb, err_clr,
      output digit_q, upd, err, seg, an
   );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder with blanking; invalid codes show a dash.
module bcd_to_7seg
   import bcd_disp_pkg::*;
(
   input  logic [3:0] code,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      if (blank) begin
         seg = SEG_BLANK;
      end else if (code > 4'd9) begin
         seg = SEG_DASH;
      end else begin
         seg = SEG_PAT[code];
      end
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Synchronises and debounces a ripple BCD counter word, then scans it onto a
// multiplexed active-low 7-segment display.
module bcd_display_scanner
   import bcd_disp_pkg::*;
#(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned STABLE_CYC = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   bcd_display_scanner_if.slave  bus
);

   localparam int unsigned W  = 4 * DIGITS;
   localparam int unsigned IW = idx_width(DIGITS);
   localparam int unsigned PW = $clog2(SCAN_DIV);
   localparam int unsigned SW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;

   logic [W-1:0]      sync1_q, s_q, cap_q;
   logic [SW-1:0]     stab_q, stab_d;
   logic              upd_q, err_q;
   logic [PW-1:0]     pre_q;
   logic [IW-1:0]     idx_q;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] an_q, an_d;

   logic              stab_full, capture, cap_invalid, pre_wrap;
   logic [3:0]        cur_code;
   logic              cur_blank, hi_zero;

   // The saturated count alone would accept a value on the very edge where s
   // moves away from it; also requiring the new sample to match rejects that.
   assign stab_full = (stab_q == SW'(STABLE_CYC - 1));
   assign capture   = stab_full && (sync1_q == s_q) && (s_q != cap_q) && !bus.freeze;
   assign pre_wrap  = (pre_q == PW'(SCAN_DIV - 1));

   always_comb begin
      if (sync1_q != s_q) begin
         stab_d = '0;
      end else if (stab_full) begin
         stab_d = stab_q;
      end else begin
         stab_d = stab_q + 1'b1;
      end
   end

   always_comb begin
      cap_invalid = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (s_q[4*i +: 4] > 4'd9) cap_invalid = 1'b1;
      end
   end

   // Walk from the top digit down so hi_zero means "this and all higher digits are 0"
   always_comb begin
      cur_code  = '0;
      cur_blank = 1'b0;
      hi_zero   = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         hi_zero = hi_zero && (cap_q[4*i +: 4] == 4'd0);
         if (idx_q == IW'(i)) begin
            cur_code  = cap_q[4*i +: 4];
            cur_blank = bus.lzb && (i != 0) && hi_zero;
         end
      end
   end

   bcd_to_7seg u_dec (
      .code  (cur_code),
      .blank (cur_blank),
      .seg   (seg_d)
   );

   assign an_d = ~(DIGITS'(1) << idx_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         s_q     <= '0;
         stab_q  <= '0;
         cap_q   <= '0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
         pre_q   <= '0;
         idx_q   <= '0;
         seg_q   <= SEG_BLANK;
         an_q    <= '1;
      end else begin
         sync1_q <= bus.bcd_in;
         s_q     <= sync1_q;
         stab_q  <= stab_d;
         upd_q   <= capture;
         if (capture) cap_q <= s_q;
         if (capture && cap_invalid) begin
            err_q <= 1'b1;
         end else if (bus.err_clr) begin
            err_q <= 1'b0;
         end
         pre_q <= pre_wrap ? '0 : pre_q + 1'b1;
         if (pre_wrap) begin
            idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end
         seg_q <= seg_d;
         an_q  <= an_d;
      end
   end

   assign bus.digit_q = cap_q;
   assign bus.upd     = upd_q;
   assign bus.err     = err_q;
   assign bus.seg     = seg_q;
   assign bus.an      = an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised plus directed bench for bcd_display_scanner with a window-based reference model.
module tb_bcd_display_scanner;

   localparam int unsigned DIGITS     = 4;
   localparam int unsigned SCAN_DIV   = 4;
   localparam int unsigned STABLE_CYC = 3;

   logic clk;
   logic rst_n;

   bcd_display_scanner_if #(.DIGITS(DIGITS)) bus ();

   bcd_display_scanner #(
      .DIGITS     (DIGITS),
      .SCAN_DIV   (SCAN_DIV),
      .STABLE_CYC (STABLE_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference display pattern: independent segment table and blanking rule
   function automatic logic [6:0] ref_seg(input logic [15:0] cap, input int idx, input logic lz);
      logic [6:0] pat [10];
      logic [15:0] upper;
      logic [3:0]  d;
      pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      upper = cap >> (4 * idx);
      d = upper[3:0];
      if (lz && idx > 0 && upper == 16'h0) return 7'h7F;
      if (d > 4'd9) return 7'b0111111;
      return pat[d];
   endfunction

   // Reference model: a value is taken once STABLE_CYC+1 consecutive input
   // samples agree, it differs from the held value, and freeze is low.
   typedef struct { logic [15:0] data; int cyc; } exp_t;
   exp_t        exp_q[$];
   logic [15:0] hist[$];
   int          cyc;
   logic [15:0] m_cap;
   logic        m_err;
   logic [6:0]  m_seg;
   logic [3:0]  m_an;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            cyc = 0;
            hist.delete();
            for (int i = 0; i <= STABLE_CYC; i++) hist.push_back(16'h0);
            m_cap = 16'h0;
            m_err = 1'b0;
            exp_q.delete();
         end else begin
            bit   same;
            bit   bad;
            int   idx;
            cyc++;
            idx   = ((cyc - 1) / SCAN_DIV) % DIGITS;
            m_seg = ref_seg(m_cap, idx, bus.lzb);
            m_an  = ~(4'd1 << idx);
            same  = 1'b1;
            for (int i = 1; i <= STABLE_CYC; i++) if (hist[i] != hist[0]) same = 1'b0;
            if (same && hist[0] != m_cap && !bus.freeze) begin
               m_cap = hist[0];
               exp_q.push_back('{data: m_cap, cyc: cyc});
               bad = 1'b0;
               for (int d = 0; d < DIGITS; d++) if (((m_cap >> (4 * d)) & 16'hF) > 9) bad = 1'b1;
               if (bad) m_err = 1'b1;
               else if (bus.err_clr) m_err = 1'b0;
            end else if (bus.err_clr) begin
               m_err = 1'b0;
            end
            void'(hist.pop_front());
            hist.push_back(bus.bcd_in);
         end
      end
   end

   // Monitor: per-cycle state comparison plus scoreboard on every upd pulse
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && cyc > 0) begin
            chk("digit_q", bus.digit_q, m_cap);
            chk("err", bus.err, m_err);
            chk("seg", bus.seg, m_seg);
            chk("an", bus.an, m_an);
            if (bus.upd) begin
               if (exp_q.size() == 0) begin
                  fail_now($sformatf("unexpected upd with digit_q=%h", bus.digit_q));
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("upd data", bus.digit_q, e.data);
                  chk("upd cycle", cyc, e.cyc);
               end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
               fail_now($sformatf("missed upd for %h", exp_q[0].data));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_upd(input string name, input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (bus.upd) return;
      end
      fail_now({name, " upd timeout"});
   endtask

   // Aligns to the first cycle of slot 0 and checks one full scan frame
   task automatic check_scan(input string name, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
      logic [3:0] prev;
      logic [6:0] exp_seg [4];
      logic [3:0] exp_an;
      bit         found;
      exp_seg = '{e0, e1, e2, e3};
      found = 1'b0;
      prev = bus.an;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (prev == 4'h7 && bus.an == 4'hE) found = 1'b1;
         prev = bus.an;
      end
      if (!found) begin
         fail_now({name, " scan alignment timeout"});
         return;
      end
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < SCAN_DIV; c++) begin
            if (s != 0 || c != 0) @(negedge clk);
            exp_an = ~(4'd1 << s);
            chk($sformatf("%s an slot%0d", name, s), bus.an, exp_an);
            chk($sformatf("%s seg slot%0d", name, s), bus.seg, exp_seg[s]);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n       = 1'b0;
      bus.bcd_in  = 16'h1234;
      bus.freeze  = 1'b0;
      bus.lzb     = 1'b0;
      bus.err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset seg", bus.seg, 7'h7F);
      chk("reset an", bus.an, 4'hF);
      chk("reset digit_q", bus.digit_q, 16'h0);
      chk("reset err", bus.err, 1'b0);
      chk("reset upd", bus.upd, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first edge an", bus.an, 4'hE);
      chk("first edge seg", bus.seg, 7'h40);
      wait_upd("post-reset", 20);
      chk("post-reset capture", bus.digit_q, 16'h1234);

      check_scan("scan 1234", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);

      // Clean step: capture on exactly the 5th edge after the change
      bus.bcd_in = 16'h0000;
      repeat (10) @(negedge clk);
      bus.bcd_in = 16'h0005;
      repeat (4) @(negedge clk);
      chk("step before edge5", bus.digit_q, 16'h0000);
      @(negedge clk);
      chk("step at edge5", bus.digit_q, 16'h0005);
      chk("step upd high", bus.upd, 1'b1);
      @(negedge clk);
      chk("step upd single", bus.upd, 1'b0);

      // Ripple transient through an invalid code
      bus.bcd_in = 16'h0009;
      repeat (10) @(negedge clk);
      bus.bcd_in = 16'h000F;
      repeat (2) @(negedge clk);
      bus.bcd_in = 16'h0010;
      repeat (10) @(negedge clk);
      chk("glitch result", bus.digit_q, 16'h0010);
      chk("glitch err", bus.err, 1'b0);

      bus.lzb    = 1'b1;
      bus.bcd_in = 16'h0070;
      repeat (10) @(negedge clk);
      check_scan("lzb 0070", 7'h7F, 7'h7F, 7'b1111000, 7'b1000000);
      bus.lzb = 1'b0;

      bus.bcd_in = 16'h00A0;
      repeat (10) @(negedge clk);
      chk("invalid sets err", bus.err, 1'b1);
      check_scan("dash 00A0", 7'b1000000, 7'b1000000, 7'b0111111, 7'b1000000);

      // err_clr on the same edge as a new invalid capture: set wins
      bus.bcd_in = 16'h00B0;
      repeat (STABLE_CYC + 1) @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      chk("set wins digit_q", bus.digit_q, 16'h00B0);
      chk("set wins err", bus.err, 1'b1);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      chk("err_clr alone", bus.err, 1'b0);

      bus.freeze = 1'b1;
      bus.bcd_in = 16'h0042;
      repeat (10) @(negedge clk);
      chk("freeze holds", bus.digit_q, 16'h00B0);
      bus.freeze = 1'b0;
      @(negedge clk);
      chk("freeze release capture", bus.digit_q, 16'h0042);

      // Asynchronous reset in the middle of a scan slot
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset an", bus.an, 4'hF);
      chk("async reset seg", bus.seg, 7'h7F);
      chk("async reset digit_q", bus.digit_q, 16'h0);
      chk("async reset upd", bus.upd, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("restart an", bus.an, 4'hE);

      for (int it = 0; it < 300; it++) begin
         logic [15:0] v;
         int hold;
         for (int d = 0; d < DIGITS; d++) begin
            logic [3:0] dig;
            dig = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) dig = 4'($urandom_range(10, 15));
            v[4*d +: 4] = dig;
         end
         if ($urandom_range(0, 2) == 0) v[15:8] = 8'h00;
         bus.bcd_in = v;
         bus.lzb    = 1'($urandom_range(0, 1));
         bus.freeze = ($urandom_range(0, 7) == 0);
         hold = $urandom_range(1, 7);
         for (int h = 0; h < hold; h++) begin
            bus.err_clr = ($urandom_range(0, 5) == 0);
            @(negedge clk);
         end
      end

      bus.freeze  = 1'b0;
      bus.err_clr = 1'b0;
      repeat (12) @(negedge clk);
      chk("scoreboard drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
